// File: rtl/sva_stim_pkg.sv
// Shared types and constants for the SVA checker stimulus generator.
package sva_stim_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_PRE, S_ASSERT_A, S_MID, S_ASSERT_B, S_NEXT, S_DONE
  } stim_fsm_t;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          RST_CYCLES = 2;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sva_gclk_div.sv
// Free-running sys_clk divider producing gclk plus rise/fall strobes that are
// high during the sys_clk cycle whose closing edge toggles gclk.
module sva_gclk_div #(
  parameter int HALF_PERIOD = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic o_gclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [HW-1:0] r_hp_cnt;
  logic          r_gclk;
  logic          w_tc;

  assign w_tc = (r_hp_cnt == HW'(HALF_PERIOD - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hp_cnt <= '0;
      r_gclk   <= 1'b0;
    end else if (w_tc) begin
      r_hp_cnt <= '0;
      r_gclk   <= ~r_gclk;
    end else begin
      r_hp_cnt <= r_hp_cnt + HW'(1);
    end
  end

  assign o_gclk = r_gclk;
  assign o_rise = w_tc & ~r_gclk;
  assign o_fall = w_tc & r_gclk;

endmodule

// File: rtl/sva_stim_gen.sv
// Drives gclk/grst and the scripted "a ##[1+] b" stimulus with an expected-success strobe.
// Define SVA_STIM_LFSR_EN to draw per-transaction gap lengths from a 16-bit LFSR.
module sva_stim_gen
  import sva_stim_pkg::*;
#(
  parameter int          HALF_PERIOD = 4,
  parameter int          GAP_WIDTH   = 4,
  parameter int          CNT_WIDTH   = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [GAP_WIDTH-1:0] cfg_pre_gap,
  input  logic [GAP_WIDTH-1:0] cfg_mid_gap,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  output logic                 gclk,
  output logic                 grst,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 expect_succ,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] txn_cnt
);

  logic                 w_gclk, w_rise, w_fall;
  stim_fsm_t            r_state;
  logic                 r_grst, r_a, r_b, r_busy, r_succ, r_done;
  logic                 r_start_pend, r_stop_pend;
  logic [GAP_WIDTH-1:0] r_gcnt, r_pre_gap, r_mid_gap, w_pre_nxt, w_mid_nxt;
  logic [CNT_WIDTH-1:0] r_count, r_txn_cnt;
  logic                 w_idle_like, w_last, w_txn_begin;
  stim_fsm_t            w_first_state;

  sva_gclk_div #(.HALF_PERIOD(HALF_PERIOD)) u_div (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .o_gclk   (w_gclk),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  // Evaluated only while leaving ASSERT_B: a same-cycle stop still ends the run
  assign w_last = r_stop_pend | stop |
                  ((|r_count) && (({1'b0, r_txn_cnt} + (CNT_WIDTH+1)'(1)) == {1'b0, r_count}));
  assign w_txn_begin = w_fall &&
                       (((r_state == S_RST) && (r_gcnt == GAP_WIDTH'(RST_CYCLES - 1))) ||
                        ((r_state == S_ASSERT_B) && !w_last));
  assign w_first_state = (w_pre_nxt == '0) ? S_ASSERT_A : S_PRE;

`ifdef SVA_STIM_LFSR_EN
  logic [15:0] r_lfsr, w_lfsr_nxt;

  assign w_lfsr_nxt = lfsr_step(r_lfsr);
  assign w_pre_nxt  = w_lfsr_nxt[GAP_WIDTH-1:0];
  assign w_mid_nxt  = w_lfsr_nxt[2*GAP_WIDTH-1:GAP_WIDTH];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)       r_lfsr <= LFSR_SEED;
    else if (w_txn_begin) r_lfsr <= w_lfsr_nxt;
  end
`else
  logic w_unused_seed;

  assign w_pre_nxt     = r_pre_gap;
  assign w_mid_nxt     = r_mid_gap;
  assign w_unused_seed = ^LFSR_SEED;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_grst       <= 1'b1;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_succ       <= 1'b0;
      r_done       <= 1'b0;
      r_start_pend <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_gcnt       <= '0;
      r_pre_gap    <= '0;
      r_mid_gap    <= '0;
      r_count      <= '0;
      r_txn_cnt    <= '0;
    end else begin
      r_succ <= w_rise && (r_state == S_ASSERT_B);
      if (stop && !w_idle_like) r_stop_pend <= 1'b1;
      if (w_fall) begin
        case (r_state)
          S_IDLE, S_DONE: if (r_start_pend) begin
            r_state   <= S_RST;
            r_grst    <= 1'b1;
            r_gcnt    <= '0;
            r_txn_cnt <= '0;
            r_done    <= 1'b0;
          end
          S_RST: begin
            if (r_gcnt != GAP_WIDTH'(RST_CYCLES - 1)) r_gcnt <= r_gcnt + GAP_WIDTH'(1);
            else                                      r_grst <= 1'b0;
          end
          S_PRE: begin
            if (r_gcnt == r_pre_gap - GAP_WIDTH'(1)) begin
              r_state <= S_ASSERT_A;
              r_a     <= 1'b1;
            end else r_gcnt <= r_gcnt + GAP_WIDTH'(1);
          end
          S_ASSERT_A: begin
            r_a    <= 1'b0;
            r_gcnt <= '0;
            if (r_mid_gap == '0) begin
              r_state <= S_ASSERT_B;
              r_b     <= 1'b1;
            end else r_state <= S_MID;
          end
          S_MID: begin
            if (r_gcnt == r_mid_gap - GAP_WIDTH'(1)) begin
              r_state <= S_ASSERT_B;
              r_b     <= 1'b1;
            end else r_gcnt <= r_gcnt + GAP_WIDTH'(1);
          end
          S_ASSERT_B: begin
            r_b <= 1'b0;
            if (r_txn_cnt != '1) r_txn_cnt <= r_txn_cnt + CNT_WIDTH'(1);
            if (w_last) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_start_pend <= 1'b0;
              r_stop_pend  <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
        // Shared entry into a transaction, from RST or straight after ASSERT_B
        if (w_txn_begin) begin
          r_state   <= w_first_state;
          r_a       <= (w_pre_nxt == '0);
          r_gcnt    <= '0;
          r_pre_gap <= w_pre_nxt;
          r_mid_gap <= w_mid_nxt;
        end
      end
      if (start && w_idle_like) begin
        r_start_pend <= 1'b1;
        r_busy       <= 1'b1;
        r_pre_gap    <= cfg_pre_gap;
        r_mid_gap    <= cfg_mid_gap;
        r_count      <= cfg_count;
      end
    end
  end

  assign gclk        = w_gclk;
  assign grst        = r_grst;
  assign a           = r_a;
  assign b           = r_b;
  assign busy        = r_busy;
  assign expect_succ = r_succ;
  assign done        = r_done;
  assign txn_cnt     = r_txn_cnt;

endmodule

// File: doc/sva_stim_gen.md
# sva_stim_gen

Stimulus driver for the synthesized SVA checker FSMs in `demo/fsm`. It generates the user clock `gclk` and user reset `grst` by dividing `sys_clk`. It drives inputs `a`/`b` with the scripted sequence `a ##[1+] b`, which is a pre-gap of `!a`, one cycle of `a`, a mid-gap of `!b`, then one cycle of `b`. It emits an expected-success strobe for every sequence it drives, so a bench can compare it with the checker's `succ`/`fail`.

## Interface
Parameters:
- `HALF_PERIOD`, default 4: `sys_clk` cycles per `gclk` half-period. Must be ≥ 2 so the checker's edge detector sees every edge.
- `GAP_WIDTH`, default 4: width of the gap-length fields.
- `CNT_WIDTH`, default 16: width of the transaction count and counter.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. Used only with `SVA_STIM_LFSR_EN`.

Ports:
- `sys_clk` input 1: system clock. This is the only clock.
- `sys_rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: one-cycle pulse that begins a run. Accepted only in IDLE or DONE.
- `stop` input 1: pulse that finishes the current transaction, then goes to DONE.
- `cfg_pre_gap` input GAP_WIDTH: number of `gclk` cycles with `a=0` before `a=1`.
- `cfg_mid_gap` input GAP_WIDTH: number of `gclk` cycles with `a=0,b=0` between `a` and `b`.
- `cfg_count` input CNT_WIDTH: transactions per run. 0 means run until `stop`.
- `gclk` output 1: divided user clock.
- `grst` output 1: user reset, active-high.
- `a`, `b` output 1 each: stimulus.
- `busy` output 1: high from an accepted `start` until DONE.
- `expect_succ` output 1: one `sys_clk` pulse per completed sequence.
- `done` output 1: level, high in DONE.
- `txn_cnt` output CNT_WIDTH: completed transactions.

## Operation
- **Divider:**
  - `hp_cnt` counts 0..HALF_PERIOD-1. At terminal count `gclk` toggles.
  - The divider runs continuously after reset.
  - `rise` and `fall` are one-cycle strobes on the same `sys_clk` edge as the toggle.
- **State machine:** states are IDLE, RST, PRE, ASSERT_A, MID, ASSERT_B, NEXT, DONE.
- **Transitions happen only on a `fall` strobe.** Therefore `a`/`b`/`grst` change half a period before the `gclk` rising edge that samples them.
- **IDLE / DONE:**
  - A `start` pulse sets `start_pend`.
  - `cfg_*` values are latched into internal registers on the `start` cycle.
  - `busy` rises on the cycle after `start`.
  - At the next `fall`, go to RST and clear `txn_cnt` and `done`.
- **RST:** `grst=1` for 2 `gclk` cycles, then PRE.
- **PRE:**
  - `a=0, b=0` for `pre_gap` cycles, then ASSERT_A.
  - If `pre_gap=0`, PRE is skipped (RST or NEXT goes directly to ASSERT_A).
- **ASSERT_A:** `a=1` for 1 cycle, then MID, or ASSERT_B if `mid_gap=0`.
- **MID:** `a=0, b=0` for `mid_gap` cycles, then ASSERT_B.
- **ASSERT_B:** `a=0, b=1` for 1 cycle, then NEXT.
- **NEXT (zero-length decision on the `fall` that leaves ASSERT_B):**
  - `txn_cnt` increments by 1.
  - Go to DONE if `stop` is pending or `txn_cnt+1 == count` (with `count≠0`).
  - Otherwise start the next transaction at PRE/ASSERT_A. There is no second RST.
- **`expect_succ`:** pulses on the `rise` strobe during ASSERT_B, i.e. the `gclk` edge at which `b=1` is sampled.
- **`stop`:** sets `stop_pend`. It is ignored in IDLE/DONE. Both `stop_pend` and `start_pend` clear on entry to DONE.
- **DONE:** `done=1`, `busy=0`, `a=b=0`, `grst=0`.
- **Counter:** `txn_cnt` saturates at all-ones and does not wrap.
- **Same-cycle `start` and `stop` in IDLE:** `start` wins and `stop` is dropped.

## Timing
- **Reset values:**
  - `gclk=0`, `grst=1`, `a=0`, `b=0`, `busy=0`, `expect_succ=0`, `done=0`, `txn_cnt=0`.
  - `hp_cnt=0`, state IDLE, LFSR=`LFSR_SEED`.
- **`grst` after reset:** stays 1 in IDLE after reset until the first RST completes.
- **`gclk` period:** 2·HALF_PERIOD `sys_clk` cycles. The first rising toggle occurs HALF_PERIOD cycles after reset release.
- **Start latency:** from `start` to the first `fall`, between 1 and 2·HALF_PERIOD `sys_clk` cycles.
- **Transaction length:** `pre_gap + mid_gap + 2` `gclk` cycles.
- **Outputs are registered.** `a`/`b`/`grst` update on the same `sys_clk` edge as the `gclk` 1→0 toggle.
- **Reset asserted mid-run:** every output returns to its reset value immediately. No transaction is completed or counted.

## Configuration
- **`SVA_STIM_LFSR_EN` defined:**
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) advances once per transaction, on entry to PRE/ASSERT_A.
  - `pre_gap` = `lfsr[GAP_WIDTH-1:0]` and `mid_gap` = `lfsr[2*GAP_WIDTH-1:GAP_WIDTH]`.
  - `cfg_pre_gap` and `cfg_mid_gap` are ignored.
- **Undefined:** the LFSR logic is absent and the latched `cfg_*` values are used for every transaction.

## Structure
- **Package `sva_stim_pkg`:** the state enum `stim_fsm_t`, the LFSR tap constant, and the RST length constant (2).
- **Sub-module `sva_gclk_div`:** holds `hp_cnt`, `gclk`, and the `rise`/`fall` strobes. It is parameterized by HALF_PERIOD and instantiated once.

## Test plan
- **Single transaction:** HALF_PERIOD=4, `pre=2`, `mid=3`, `count=1`, `start`.
  - `grst` high for 2 `gclk` cycles; `a` high for exactly 1 `gclk` cycle, after 2 cycles of `!a`.
  - `b` high for 1 cycle after 3 cycles of `!b`; exactly one `expect_succ` pulse.
  - Then `done=1`, `busy=0`, `txn_cnt=1`.
- **Zero gaps:** `pre=0`, `mid=0`, `count=3` gives `a`,`b`,`a`,`b`,`a`,`b` on consecutive `gclk` cycles, 3 `expect_succ` pulses, and `txn_cnt=3`.
- **Continuous run with stop:** `count=0`, `pre=1`, `mid=1`, `stop` asserted during MID of transaction 5.
  - Transaction 5 completes; DONE with `txn_cnt=5`.
- **Reset mid-run:** `sys_rst_n` low during MID gives all outputs at their reset values within the same cycle.
  - After release, `gclk` toggles HALF_PERIOD cycles later and state is IDLE.
- **Start ignored while busy:** a second `start` while `busy=1` has no effect on the sequence or on `txn_cnt`.
- **With `SVA_STIM_LFSR_EN`, seed 16'hACE1, `count=4`:** the gap lengths match a reference LFSR model, and there are 4 `expect_succ` pulses.
